app_mul_signed16_seq_ctrl: RTL

- Sequential controller and accumulator for one signed 16x16 multiply, built around a single signed 16x2 partial-product layer with an 18-bit output.
- Upstream role: holds operand A and walks multiplier B two bits per cycle, LSB pair first. It drives the layer's A, B_low, B_high and cin inputs.
- Downstream role: takes the layer's combinational 18-bit partial product each cycle, then shifts and accumulates it into a 32-bit signed product.
- Valid/ready on both sides; one multiply in flight.

---
 rtl/app_mul_signed16_seq_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/app_mul_signed16_seq_ctrl.sv
// Sequential signed WIDTHxWIDTH multiplier controller: walks multiplier B two bits per
// cycle through an external 16x2 partial-product layer and accumulates the result.
module app_mul_signed16_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] lyr_a,
  output logic             lyr_b_low,
  output logic             lyr_b_high,
  output logic             lyr_last,
  output logic             lyr_cin,
  input  logic [WIDTH+1:0] lyr_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_p,
  output logic             busy
);

  localparam int STEPS = WIDTH / 2;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [SW-1:0]    step;
  logic [PW-1:0]    acc;
  logic             is_last;
  logic [PW-1:0]    pp_ext;

  assign is_last = (step == SW'(STEPS - 1));
  assign pp_ext  = {{(PW - WIDTH - 2){lyr_sum[WIDTH+1]}}, lyr_sum};

  // Layer drive is decoded from registered state; digit selects are zeroed outside RUN.
  assign lyr_a      = a_r;
  assign lyr_b_low  = (state == RUN) && b_r[{step, 1'b0}];
  assign lyr_b_high = (state == RUN) && b_r[{step, 1'b1}];
  assign lyr_last   = (state == RUN) && is_last;
  assign lyr_cin    = 1'b0;
  assign out_p      = acc;

  // NOTE: every register in this block uses <=, so all branches see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      step      <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            step     <= '0;
            acc      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Wraps modulo 2^PW; the last signed digit restores the exact product.
          acc  <= acc + (pp_ext << {step, 1'b0});
          step <= step + 1'b1;
          if (is_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
